// File: rtl/multicycle_issue_ctrl.sv
// multicycle_issue_ctrl: scoreboard, per-unit start/done FSMs and a
// fixed-priority arbiter onto the spare register-file write port.
module multicycle_issue_ctrl #(
  parameter int NUM_UNITS = 2,
  parameter int UNIT_W    = 1,
  parameter int OP_W      = 2,
  parameter int DATA_W    = 32
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        IssueValid,
  input  logic                        IssueMulti,
  input  logic [UNIT_W-1:0]           IssueUnit,
  input  logic [OP_W-1:0]             IssueOp,
  input  logic [3:0]                  IssueRd,
  input  logic                        IssueRegW,
  input  logic [3:0]                  SrcRn,
  input  logic [3:0]                  SrcRm,
  input  logic                        SrcUseRn,
  input  logic                        SrcUseRm,
  output logic                        Stall,
  output logic                        IllegalIssue,
  output logic [NUM_UNITS-1:0]        UnitStart,
  output logic [NUM_UNITS*OP_W-1:0]   UnitOp,
  input  logic [NUM_UNITS-1:0]        UnitDone,
  input  logic [NUM_UNITS*DATA_W-1:0] UnitResult,
  input  logic                        WBPortFree,
  output logic                        WBEn,
  output logic [3:0]                  WBAddr,
  output logic [DATA_W-1:0]           WBData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_HOLD
  } st_e;

  st_e               st_q  [NUM_UNITS];
  st_e               st_d  [NUM_UNITS];
  logic [OP_W-1:0]   op_q  [NUM_UNITS];
  logic [OP_W-1:0]   op_d  [NUM_UNITS];
  logic [3:0]        rd_q  [NUM_UNITS];
  logic [3:0]        rd_d  [NUM_UNITS];
  logic [DATA_W-1:0] res_q [NUM_UNITS];
  logic [DATA_W-1:0] res_d [NUM_UNITS];

  logic [14:0]          busy_q, busy_d;
  logic [NUM_UNITS-1:0] start_q, start_d;

  logic [15:0]       busy16;
  logic              unit_ok;
  logic              sel_busy;
  logic              illegal;
  logic              hazard;
  logic              accept;
  logic              gnt_any;
  logic [UNIT_W-1:0] gnt_idx;

  // r15 reads as never busy; rejected ops never stall
  always_comb begin
    busy16   = {1'b0, busy_q};
    unit_ok  = 32'(IssueUnit) < NUM_UNITS;
    sel_busy = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (UNIT_W'(i) == IssueUnit && st_q[i] != S_IDLE)
        sel_busy = 1'b1;
    end
    illegal = IssueValid & IssueMulti &
              ((IssueRd == 4'd15) | ~unit_ok);
    hazard  = (SrcUseRn & busy16[SrcRn]) |
              (SrcUseRm & busy16[SrcRm]) |
              ((IssueRegW | IssueMulti) & busy16[IssueRd]) |
              (IssueMulti & sel_busy);
    Stall        = IssueValid & hazard & ~illegal;
    IllegalIssue = illegal;
    accept       = IssueValid & IssueMulti & ~Stall & ~illegal;
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!gnt_any && WBPortFree && st_q[i] == S_HOLD) begin
        gnt_any = 1'b1;
        gnt_idx = UNIT_W'(i);
      end
    end
    WBEn   = gnt_any;
    WBAddr = gnt_any ? rd_q[gnt_idx] : 4'd0;
    WBData = gnt_any ? res_q[gnt_idx] : '0;
  end

  always_comb begin
    UnitOp = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      UnitOp[i*OP_W +: OP_W] = op_q[i];
    UnitStart = start_q;
  end

  always_comb begin
    busy_d  = busy_q;
    start_d = '0;
    if (gnt_any && rd_q[gnt_idx] != 4'd15)
      busy_d[rd_q[gnt_idx]] = 1'b0;
    if (accept)
      busy_d[IssueRd] = 1'b1;
    for (int i = 0; i < NUM_UNITS; i++) begin
      st_d[i]  = st_q[i];
      op_d[i]  = op_q[i];
      rd_d[i]  = rd_q[i];
      res_d[i] = res_q[i];
      unique case (1'b1)
        st_q[i] == S_IDLE: begin
          if (accept && UNIT_W'(i) == IssueUnit) begin
            st_d[i]    = S_START;
            op_d[i]    = IssueOp;
            rd_d[i]    = IssueRd;
            start_d[i] = 1'b1;
          end
        end
        st_q[i] == S_START: st_d[i] = S_RUN;
        st_q[i] == S_RUN: begin
          if (UnitDone[i]) begin
            st_d[i]  = S_HOLD;
            res_d[i] = UnitResult[i*DATA_W +: DATA_W];
          end
        end
        st_q[i] == S_HOLD: begin
          if (gnt_any && gnt_idx == UNIT_W'(i))
            st_d[i] = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy_q  <= '0;
      start_q <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        st_q[i]  <= S_IDLE;
        op_q[i]  <= '0;
        rd_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      start_q <= start_d;
      for (int i = 0; i < NUM_UNITS; i++) begin
        st_q[i]  <= st_d[i];
        op_q[i]  <= op_d[i];
        rd_q[i]  <= rd_d[i];
        res_q[i] <= res_d[i];
      end
    end
  end

endmodule

// File: doc/multicycle_issue_ctrl.md
# multicycle_issue_ctrl

Sequential issue/writeback controller sitting beside the decode-stage control unit. It accepts multi-cycle operations (MUL/DIV on the MCycle unit, FPU ops, and any future long-latency unit) and launches each on its unit with a start/done handshake. It tracks pending destination registers in a scoreboard, stalls the pipeline front end on data and structural hazards, and arbitrates unit results onto the spare register-file write port. It generalises the single MS/FPUS start decision to NUM_UNITS independent units.

## Interface
- NUM_UNITS, 2, number of multi-cycle units (unit 0 = MCycle, unit 1 = FPU).
- UNIT_W, 1, width of unit index, ≥ clog2(NUM_UNITS).
- OP_W, 2, width of per-unit operation code (MCycleOp/FPUOp generalised).
- DATA_W, 32, result width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IssueValid  in  1  decode-stage instruction valid.
- IssueMulti  in  1  instruction targets a multi-cycle unit.
- IssueUnit  in  UNIT_W  target unit index.
- IssueOp  in  OP_W  unit operation.
- IssueRd  in  4  destination register.
- IssueRegW  in  1  single-cycle instruction writes IssueRd.
- SrcRn, SrcRm  in  4 each  source registers.
- SrcUseRn, SrcUseRm  in  1 each  source actually read.
- Stall  out  1  hold decode/fetch this cycle.
- IllegalIssue  out  1  one-cycle pulse, multi-cycle op rejected.
- UnitStart  out  NUM_UNITS  one-cycle start pulse per unit.
- UnitOp  out  NUM_UNITS*OP_W  operation latched per unit, stable from start until done.
- UnitDone  in  NUM_UNITS  result valid pulse per unit.
- UnitResult  in  NUM_UNITS*DATA_W  result buses.
- WBPortFree  in  1  pipeline not using the write port this cycle.
- WBEn  out  1  write-back strobe.
- WBAddr  out  4  write-back register.
- WBData  out  DATA_W  write-back data.

## Operation
- Scoreboard: 15 busy bits (r0–r14). r15 is never busy.
- Hazard: Stall=1 when IssueValid and any of the following holds:
  - a used source is busy;
  - (IssueRegW | IssueMulti) and IssueRd is busy;
  - IssueMulti and the target unit's FSM is not IDLE.
- Accept: an instruction is accepted when IssueValid & IssueMulti & ~Stall & IssueRd≠15 & IssueUnit<NUM_UNITS.
  - On acceptance, set busy[IssueRd], latch IssueOp and IssueRd into the unit slot, and move the unit to START.
- Reject: IssueMulti with IssueRd=15 or an out-of-range unit index pulses IllegalIssue for one cycle. The instruction is not accepted, no state changes, and Stall stays 0.
- Per-unit FSM:
  - IDLE → START on accept.
  - START (UnitStart=1) → RUN unconditionally.
  - RUN → HOLD when UnitDone is sampled; the unit's UnitResult is captured into a hold register. UnitDone is ignored outside RUN.
  - HOLD → IDLE on grant.
- Arbiter: grant = WBPortFree & HOLD, with fixed priority to the lowest unit index. At most one grant per cycle.
  - While a unit holds the grant, WBEn=1 and WBAddr/WBData come from that unit's slot (combinational).
  - The granted unit's busy bit is cleared on the same edge.

## Timing
- Reset values: all FSMs IDLE, scoreboard 0, Stall=0, IllegalIssue=0, UnitStart=0, UnitOp=0, WBEn=0, WBAddr=0, WBData=0. Reset is effective immediately and asynchronously, also mid-operation: in-flight results are discarded and late UnitDone pulses are ignored.
- Stall, IllegalIssue and WB outputs are combinational from current state and inputs. UnitStart is registered.
- Accept at edge k → UnitStart high in cycle k+1 → RUN from edge k+2.
- UnitDone at edge d → HOLD in cycle d+1. WBEn is asserted in cycle d+1 at the earliest.
- Minimum issue-to-writeback latency is 3 cycles plus the unit latency.
- There is no bypass. A busy bit cleared on the grant edge g unblocks a dependent instruction from cycle g+1 at the earliest, so a dependent instruction presented during the grant cycle stalls.
- Back-to-back issue to the same unit is allowed from the cycle its FSM returns to IDLE.
- Simultaneous grant and accept to the same Rd: the bit is still set at decision time, so the accept is stalled one cycle.

## Test plan
- MUL on unit 0, Rd=r3, UnitDone 4 cycles after start, WBPortFree=1 → UnitStart pulses at k+1, WBEn=1 with WBAddr=3 and WBData equal to the result exactly once, busy[3] cleared.
- ADD reading r3 issued while MUL to r3 is pending → Stall=1 until the cycle after WBEn; no stall when reading r4.
- Units 0 and 1 complete on the same edge with WBPortFree=1 → unit 0 writes in cycle n and unit 1 in cycle n+1; with WBPortFree=0 for 3 cycles, both hold and their results are unchanged.
- Second FPU op while the FPU is in RUN → Stall=1, no second UnitStart; it is accepted the cycle after the FPU returns to IDLE.
- Multi-cycle op with Rd=15 → IllegalIssue=1 for one cycle, no UnitStart, scoreboard unchanged.
- RESET_N low during RUN, followed by UnitDone → all outputs return to reset values immediately and no WBEn follows.
